// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered frames applied only at
// the scan-frame boundary, anti-ghost blanking at each digit slot and flash gating.
module seg_scan_driver #(
  parameter int unsigned DIGITS     = 5,
  parameter int unsigned SCAN_DIV   = 20000,
  parameter int unsigned BLANK_CYC  = 200,
  parameter int unsigned FLASH_HALF = 2000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   frame_data,
  input  logic [1:0]            frame_mode,
  input  logic                  frame_load,
  output logic                  frame_upd,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [7:0]            seg_out
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned IDX_W = (DIGITS > 1)     ? $clog2(DIGITS)     : 1;
  localparam int unsigned FL_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'b00,
    MODE_FLASH  = 2'b01,
    MODE_BLANK  = 2'b10,
    MODE_CONST2 = 2'b11
  } mode_e;

  logic [DIV_W-1:0]    div_cnt_q,   div_cnt_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
  logic [FL_W-1:0]     flash_cnt_q, flash_cnt_d;
  logic                flash_on_q,  flash_on_d;
  logic [8*DIGITS-1:0] act_data_q,  act_data_d;
  mode_e               act_mode_q,  act_mode_d;
  logic [8*DIGITS-1:0] pend_data_q, pend_data_d;
  mode_e               pend_mode_q, pend_mode_d;
  logic                pend_flag_q, pend_flag_d;
  logic                frame_upd_q, frame_upd_d;
  logic [DIGITS-1:0]   dig_sel_q,   dig_sel_d;
  logic [7:0]          seg_out_q,   seg_out_d;

  logic  div_wrap;
  logic  frame_end;
  logic  apply;
  mode_e new_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
      act_data_q  <= '0;
      act_mode_q  <= MODE_BLANK;
      pend_data_q <= '0;
      pend_mode_q <= MODE_CONST;
      pend_flag_q <= 1'b0;
      frame_upd_q <= 1'b0;
      dig_sel_q   <= '1;
      seg_out_q   <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      act_data_q  <= act_data_d;
      act_mode_q  <= act_mode_d;
      pend_data_q <= pend_data_d;
      pend_mode_q <= pend_mode_d;
      pend_flag_q <= pend_flag_d;
      frame_upd_q <= frame_upd_d;
      dig_sel_q   <= dig_sel_d;
      seg_out_q   <= seg_out_d;
    end
  end

  // Scan counters
  always_comb begin
    div_wrap    = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_end   = div_wrap && (digit_idx_q == IDX_W'(DIGITS - 1));
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (div_wrap) begin
      digit_idx_d = (digit_idx_q == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
    end
  end

  // A load on the frame-end cycle bypasses the pending buffer entirely.
  always_comb begin
    apply       = frame_end && (frame_load || pend_flag_q);
    new_mode    = frame_load ? mode_e'(frame_mode) : pend_mode_q;
    act_data_d  = act_data_q;
    act_mode_d  = act_mode_q;
    pend_data_d = pend_data_q;
    pend_mode_d = pend_mode_q;
    pend_flag_d = pend_flag_q;
    frame_upd_d = apply;
    if (frame_end) begin
      pend_flag_d = 1'b0;
      if (apply) begin
        act_data_d = frame_load ? frame_data : pend_data_q;
        act_mode_d = new_mode;
      end
    end else if (frame_load) begin
      pend_data_d = frame_data;
      pend_mode_d = mode_e'(frame_mode);
      pend_flag_d = 1'b1;
    end
  end

  // Flash timer restarts visible only when the applied mode actually changes
  always_comb begin
    flash_cnt_d = flash_cnt_q + 1'b1;
    flash_on_d  = flash_on_q;
    if (apply && (new_mode != act_mode_q)) begin
      flash_cnt_d = '0;
      flash_on_d  = 1'b1;
    end else if (flash_cnt_q == FL_W'(FLASH_HALF - 1)) begin
      flash_cnt_d = '0;
      flash_on_d  = ~flash_on_q;
    end
  end

  always_comb begin
    dig_sel_d = '1;
    seg_out_d = '0;
    if ((div_cnt_q >= DIV_W'(BLANK_CYC)) && (act_mode_q != MODE_BLANK) &&
        !((act_mode_q == MODE_FLASH) && !flash_on_q)) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (digit_idx_q == IDX_W'(i)) begin
          dig_sel_d = ~(DIGITS'(1) << i);
          seg_out_d = act_data_q[8*(DIGITS-1-i) +: 8];
        end
      end
    end
  end

  assign frame_upd = frame_upd_q;
  assign dig_sel   = dig_sel_q;
  assign seg_out   = seg_out_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan table, double buffering, frame-end
// bypass, flash phase behaviour and mid-scan reset.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] frame_data;
  logic [1:0]  frame_mode;
  logic        frame_load;
  logic        frame_upd;
  logic [4:0]  dig_sel;
  logic [7:0]  seg_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [39:0] DATA_A  = 40'h3F_06_5B_4F_66;
  localparam logic [39:0] DATA_A2 = 40'h11_22_33_44_55;
  localparam logic [39:0] DATA_B  = 40'h7F_6D_77_39_5E;
  localparam logic [39:0] DATA_C  = 40'h80_71_1C_3E_08;

  typedef struct {
    int unsigned idx;
    logic [4:0]  dig;
    logic [7:0]  seg;
  } vec_t;

  vec_t tbl [5];

  seg_scan_driver #(
    .DIGITS(5),
    .SCAN_DIV(8),
    .BLANK_CYC(2),
    .FLASH_HALF(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_data(frame_data),
    .frame_mode(frame_mode),
    .frame_load(frame_load),
    .frame_upd(frame_upd),
    .dig_sel(dig_sel),
    .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [39:0] d, input logic [1:0] m);
    @(negedge clk);
    frame_data = d;
    frame_mode = m;
    frame_load = 1'b1;
    @(negedge clk);
    frame_load = 1'b0;
  endtask

  task automatic wait_upd(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (frame_upd === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 40'(seen), 40'd1);
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_dig"}, 40'(dig_sel), 40'h1F);
      chk({name, "_seg"}, 40'(seg_out), 40'h00);
      chk({name, "_upd"}, 40'(frame_upd), 40'd0);
    end
  endtask

  // Starts on the negedge where frame_upd was seen (counters at div 0, digit 0).
  // Cycle j shows the counter state s=j-1; data switches to d1 for s >= sw.
  task automatic scan_check(input string name, input logic [39:0] d0, input logic [39:0] d1,
                            input int sw, input int n, input int upd_at, input bit flash);
    int s, dv, ix;
    bit vis;
    logic [39:0] d;
    logic [4:0] e_dig;
    logic [7:0] e_seg;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      s   = j - 1;
      dv  = s % 8;
      ix  = (s / 8) % 5;
      d   = (s >= sw) ? d1 : d0;
      vis = (dv >= 2) && (!flash || ((s / 64) % 2 == 0));
      e_dig = vis ? ~(5'b00001 << ix) : 5'h1F;
      e_seg = vis ? d[8*(4-ix) +: 8] : 8'h00;
      chk({name, "_dig"}, 40'(dig_sel), 40'(e_dig));
      chk({name, "_seg"}, 40'(seg_out), 40'(e_seg));
      chk({name, "_upd"}, 40'(frame_upd), (j == upd_at) ? 40'd1 : 40'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 5'h1E, 8'h3F};
    tbl[1] = '{1, 5'h1D, 8'h06};
    tbl[2] = '{2, 5'h1B, 8'h5B};
    tbl[3] = '{3, 5'h17, 8'h4F};
    tbl[4] = '{4, 5'h0F, 8'h66};

    reset      = 1'b0;
    frame_data = '0;
    frame_mode = 2'b00;
    frame_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dig", 40'(dig_sel), 40'h1F);
    chk("rst_seg", 40'(seg_out), 40'h00);
    chk("rst_upd", 40'(frame_upd), 40'd0);
    reset = 1'b1;

    idle_check("idle", 100);

    load(DATA_A, 2'b00);
    wait_upd("upd_a");
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (c < 2) begin
          chk("tbl_blank_dig", 40'(dig_sel), 40'h1F);
          chk("tbl_blank_seg", 40'(seg_out), 40'h00);
        end else begin
          chk("tbl_dig", 40'(dig_sel), 40'(tbl[s].dig));
          chk("tbl_seg", 40'(seg_out), 40'(tbl[s].seg));
        end
        chk("tbl_upd", 40'(frame_upd), 40'd0);
      end
    end

    load(DATA_A2, 2'b00);
    repeat (3) @(negedge clk);
    load(DATA_B, 2'b00);
    wait_upd("upd_b");
    scan_check("lastwins", DATA_B, DATA_B, 0, 80, -1, 1'b0);

    fork
      scan_check("bypass", DATA_B, DATA_C, 40, 80, 40, 1'b0);
      begin
        repeat (39) @(negedge clk);
        frame_data = DATA_C;
        frame_mode = 2'b00;
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
      end
    join

    repeat (13) @(negedge clk);
    load(DATA_A, 2'b01);
    wait_upd("upd_flash");
    fork
      scan_check("flash", DATA_A, DATA_B, 40, 160, 40, 1'b1);
      begin
        repeat (10) @(negedge clk);
        load(DATA_B, 2'b01);
      end
    join

    load(DATA_C, 2'b00);
    repeat (26) @(negedge clk);
    chk("pre_rst_dig", 40'(dig_sel), 40'h17);
    chk("pre_rst_seg", 40'(seg_out), 40'h39);
    #2 reset = 1'b0;
    #1;
    chk("midrst_dig", 40'(dig_sel), 40'h1F);
    chk("midrst_seg", 40'(seg_out), 40'h00);
    chk("midrst_upd", 40'(frame_upd), 40'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_check("post_rst", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Front-panel display back end. It takes the 5-digit, 40-bit display frame and display mode produced by the panel interface logic. It time-multiplexes the frame onto the 7-segment digit and segment lines, with anti-ghost blanking and flash gating. New frames are double-buffered and applied only at a scan-frame boundary, so a digit never shows part of an old frame and part of a new one.

Parameters:
DIGITS, 5, number of multiplexed digits; frame width is 8*DIGITS
SCAN_DIV, 20000, clk cycles each digit is selected (1 ms at 20 MHz)
BLANK_CYC, 200, cycles at the start of each digit slot with all digits off; must be less than SCAN_DIV
FLASH_HALF, 2000000, clk cycles per flash half-period (100 ms at 20 MHz)

Ports:
clk  in  1  system clock; the single clock of the block
reset  in  1  asynchronous, active-low reset
frame_data  in  8*DIGITS  display bytes; byte DIGITS-1 (MSBs) = leftmost digit; bit7 of each byte = decimal point, bits6:0 = segments g..a
frame_mode  in  2  00 constant, 01 flash, 10 blank, 11 treated as constant
frame_load  in  1  one-cycle strobe; captures frame_data/frame_mode into the pending buffer
frame_upd  out  1  one-cycle pulse when a new frame becomes active
dig_sel  out  DIGITS  one-hot, active-low digit enables; bit 0 = leftmost digit
seg_out  out  8  active-high segment and decimal-point drive

Behaviour:
- Reset (async, reset=0): dig_sel all 1, seg_out 0, frame_upd 0. Active and pending data 0. Active mode 10 (blank). Pending flag 0. div_cnt 0, digit_idx 0, flash_cnt 0, flash phase = on.
- Scan counter: div_cnt counts 0..SCAN_DIV-1 every clk, then wraps to 0. On wrap, digit_idx advances and wraps from DIGITS-1 to 0.
- Frame end = (div_cnt==SCAN_DIV-1 && digit_idx==DIGITS-1).
- Pending buffer:
  - frame_load writes pending data/mode and sets the pending flag.
  - A later load before the frame end overwrites the buffer; last write wins.
  - At frame end, if the pending flag is set, active <= pending, the flag clears, and frame_upd pulses in the next cycle.
  - If frame_load is high on the frame-end cycle itself, the incoming frame_data/frame_mode go straight to active (bypass), the flag clears, and frame_upd pulses.
- Flash timer:
  - flash_cnt counts 0..FLASH_HALF-1; the phase toggles at each wrap.
  - When an applied frame changes the active mode, flash_cnt resets to 0 and phase to on, so flash always starts visible.
  - Applying a frame with the same mode does not disturb the timer.
- Output registers, updated every clk:
  - If div_cnt < BLANK_CYC: dig_sel all 1, seg_out 0.
  - Else if mode==10, or mode==01 with phase off: dig_sel all 1, seg_out 0.
  - Else: dig_sel = ~(1<<digit_idx), seg_out = active byte (DIGITS-1-digit_idx).
- Latency: outputs reflect the counter state of the previous cycle (one register stage). The first visible frame after reset needs a load plus one full scan frame.
- No two digit enables are ever low in the same cycle; a digit-to-digit switch always passes through at least BLANK_CYC all-off cycles.
- Reset mid-scan returns everything to the reset state immediately. Pending data is discarded.

Test Plan:
(Bench parameters: DIGITS=5, SCAN_DIV=8, BLANK_CYC=2, FLASH_HALF=64.)
- Reset then idle -> dig_sel=5'h1F and seg_out=0 forever; frame_upd never pulses.
- Load 40'h3F_06_5B_4F_66 with mode 00 mid-frame -> frame_upd pulses once after the frame end. Each digit slot then shows 2 cycles all-off, then 6 cycles of dig_sel 5'h1E/3F, 1D/06, 1B/5B, 17/4F, 0F/66 in order.
- Load A then B within one frame -> only B becomes active; a single frame_upd pulse.
- frame_load on the exact frame-end cycle -> the new frame is active from digit 0 of the next frame; frame_upd pulses.
- Mode 01 -> 64 cycles of normal scan, then 64 cycles all-off, repeating. Reloading with mode 01 does not restart the phase; switching from 00 to 01 does.
- Assert reset during digit 3 with a frame pending -> outputs go all-off immediately. After release, the display stays blank (no frame_upd) until a new load.
